// File: rtl/moldudp64_stream_parser.sv
// MoldUDP64 parser for a byte-lane packet stream: captures the header at HDR_OFFSET
// and walks the message-block chain, queuing one {seq, offset, len} descriptor per message.
module moldudp64_stream_parser #(
  parameter int DATA_W     = 64,
  parameter int HDR_OFFSET = 42,
  parameter int DESC_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic                hdr_valid,
  output logic [79:0]         hdr_session,
  output logic [63:0]         hdr_seq,
  output logic [15:0]         hdr_count,
  output logic                hdr_heartbeat,
  output logic                hdr_end,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [63:0]         m_seq,
  output logic [15:0]         m_offset,
  output logic [15:0]         m_len,
  output logic                err_trunc,
  output logic                pkt_done,
  output logic [1:0]          dbg_state
);

  // Handshakes: a beat (or descriptor) transfers on a rising clk edge where valid
  // and ready are both high; valid never waits on ready, and the sender holds its
  // payload stable while valid is high and ready is low.

  localparam int BYTES = DATA_W / 8;
  localparam int LW    = $clog2(BYTES);
  localparam int AW    = $clog2(DESC_DEPTH);
  localparam logic [15:0] HDR_LAST  = 16'(HDR_OFFSET + 19);
  localparam logic [15:0] PTR_FIRST = 16'(HDR_OFFSET + 20);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DESC_DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, MSGS, DRAIN} state_t;

  state_t        state;
  logic [15:0]   beat_cnt;
  logic [159:0]  hdr_raw;

  // The most recently accepted beat; the message walk reads lengths from here.
  logic [DATA_W-1:0] cur_data;
  logic [15:0]       cur_base;
  logic [15:0]       cur_n;
  logic              cur_last;

  logic [15:0] ptr;
  logic [15:0] idx;
  logic [7:0]  hi_byte;
  logic        hi_pend;

  logic [95:0]   fifo_mem [DESC_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;

  logic [15:0]  in_base;
  logic [15:0]  in_n;
  logic [15:0]  in_total;
  logic [15:0]  hdr_rel [20];
  logic [159:0] hdr_next;
  logic [15:0]  cnt_in;
  logic         hdr_done_in;

  logic [15:0] rel0;
  logic [15:0] rel1;
  logic        in0;
  logic        in1;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic        field_ok;
  logic        latch_hi;
  logic [15:0] msg_len;
  logic [15:0] ptr_next;
  logic [15:0] idx_next;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        accept;

  // Incoming beat: byte position of lane 0 and number of valid lanes.
  always_comb begin
    in_n = '0;
    for (int l = 0; l < BYTES; l++) begin
      in_n = in_n + 16'(s_keep[l]);
    end
    in_base  = 16'(32'(beat_cnt) * BYTES);
    in_total = in_base + in_n;
  end

  // Merge whichever header bytes this beat carries into the collected header.
  always_comb begin
    hdr_next = hdr_raw;
    for (int k = 0; k < 20; k++) begin
      hdr_rel[k] = 16'(HDR_OFFSET + k) - in_base;
      if (hdr_rel[k] < in_n) begin
        hdr_next[8*(19-k) +: 8] = s_data[{hdr_rel[k][LW-1:0], 3'b000} +: 8];
      end
    end
    cnt_in      = hdr_next[15:0];
    hdr_done_in = (HDR_LAST - in_base) < in_n;
  end

  // Length field at ptr/ptr+1 relative to the held beat; a high byte left over
  // from the previous beat is taken from hi_byte.
  always_comb begin
    rel0     = ptr - cur_base;
    rel1     = ptr + 16'd1 - cur_base;
    in0      = rel0 < cur_n;
    in1      = rel1 < cur_n;
    byte0    = cur_data[{rel0[LW-1:0], 3'b000} +: 8];
    byte1    = cur_data[{rel1[LW-1:0], 3'b000} +: 8];
    field_ok = hi_pend ? in1 : (in0 && in1);
    latch_hi = !hi_pend && in0 && !in1;
    msg_len  = hi_pend ? {hi_byte, byte1} : {byte0, byte1};
    ptr_next = ptr + 16'd2 + msg_len;
    idx_next = idx + 16'd1;
  end

  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign push      = (state == MSGS) && field_ok && !fifo_full;
  assign pop       = m_valid && m_ready;
  assign s_ready   = (state != MSGS) || (!cur_last && !field_ok && !fifo_full);
  assign accept    = s_valid && s_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      hdr_raw       <= '0;
      cur_data      <= '0;
      cur_base      <= '0;
      cur_n         <= '0;
      cur_last      <= 1'b0;
      ptr           <= '0;
      idx           <= '0;
      hi_byte       <= '0;
      hi_pend       <= 1'b0;
      hdr_valid     <= 1'b0;
      hdr_session   <= '0;
      hdr_seq       <= '0;
      hdr_count     <= '0;
      hdr_heartbeat <= 1'b0;
      hdr_end       <= 1'b0;
      err_trunc     <= 1'b0;
      pkt_done      <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      err_trunc <= 1'b0;
      pkt_done  <= 1'b0;
      if (accept) begin
        cur_data <= s_data;
        cur_base <= in_base;
        cur_n    <= in_n;
        cur_last <= s_last;
        beat_cnt <= s_last ? 16'd0 : beat_cnt + 16'd1;
      end
      case (state)
        IDLE, HDR: begin
          if (accept) begin
            hdr_raw <= hdr_next;
            if (hdr_done_in) begin
              hdr_valid     <= 1'b1;
              hdr_session   <= hdr_next[159:80];
              hdr_seq       <= hdr_next[79:16];
              hdr_count     <= cnt_in;
              hdr_heartbeat <= (cnt_in == 16'h0000);
              hdr_end       <= (cnt_in == 16'hFFFF);
              ptr           <= PTR_FIRST;
              idx           <= '0;
              hi_pend       <= 1'b0;
              if (cnt_in == 16'h0000 || cnt_in == 16'hFFFF) begin
                if (s_last) begin
                  pkt_done  <= 1'b1;
                  err_trunc <= PTR_FIRST > in_total;
                  state     <= IDLE;
                end else begin
                  state <= DRAIN;
                end
              end else begin
                // Even on a last beat the walk runs; missing blocks flag truncation there.
                state <= MSGS;
              end
            end else if (s_last) begin
              pkt_done  <= 1'b1;
              err_trunc <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= HDR;
            end
          end
        end
        MSGS: begin
          if (push) begin
            ptr     <= ptr_next;
            idx     <= idx_next;
            hi_pend <= 1'b0;
            if (idx_next == hdr_count) begin
              if (cur_last) begin
                pkt_done  <= 1'b1;
                err_trunc <= ptr_next > (cur_base + cur_n);
                state     <= IDLE;
              end else begin
                state <= DRAIN;
              end
            end
          end else if (!field_ok) begin
            if (cur_last) begin
              pkt_done  <= 1'b1;
              err_trunc <= 1'b1;
              state     <= IDLE;
            end else if (latch_hi) begin
              hi_byte <= byte0;
              hi_pend <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept && s_last) begin
            pkt_done  <= 1'b1;
            err_trunc <= ptr > in_total;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Descriptor FIFO; full blocks both push and s_ready, so full push+pop cannot occur.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int d = 0; d < DESC_DEPTH; d++) begin
        fifo_mem[d] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {hdr_seq + {48'd0, idx}, ptr + 16'd2, msg_len};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign m_valid = (fifo_cnt != '0);
  assign m_seq    = fifo_mem[rd_ptr][95:32];
  assign m_offset = fifo_mem[rd_ptr][31:16];
  assign m_len    = fifo_mem[rd_ptr][15:0];

endmodule

// File: tb/tb_moldudp64_stream_parser.sv
// Directed bench for moldudp64_stream_parser: builds packets byte by byte, drives them
// as 64-bit beats and checks header fields, descriptors and pulses against hand values.
module tb_moldudp64_stream_parser;
  localparam int DATA_W = 64;
  localparam int BYTES  = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] s_data;
  logic [BYTES-1:0]  s_keep;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              hdr_valid;
  logic [79:0]       hdr_session;
  logic [63:0]       hdr_seq;
  logic [15:0]       hdr_count;
  logic              hdr_heartbeat;
  logic              hdr_end;
  logic              m_valid;
  logic              m_ready;
  logic [63:0]       m_seq;
  logic [15:0]       m_offset;
  logic [15:0]       m_len;
  logic              err_trunc;
  logic              pkt_done;
  logic [1:0]        dbg_state;

  moldudp64_stream_parser #(.DATA_W(DATA_W), .HDR_OFFSET(42), .DESC_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .hdr_valid(hdr_valid), .hdr_session(hdr_session), .hdr_seq(hdr_seq), .hdr_count(hdr_count),
    .hdr_heartbeat(hdr_heartbeat), .hdr_end(hdr_end),
    .m_valid(m_valid), .m_ready(m_ready), .m_seq(m_seq), .m_offset(m_offset), .m_len(m_len),
    .err_trunc(err_trunc), .pkt_done(pkt_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] pb [0:511];
  int         plen;

  // scoreboard: expected descriptors, and popped descriptors captured on the far edge
  logic [95:0] exp_q[$];
  int          acc_n = 0, hv_n = 0, pd_n = 0, et_n = 0, etpd_n = 0, got_n = 0;
  logic [95:0] got_d [0:63];
  int          rd_i = 0;
  int          acc0, hv0, pd0, et0, etpd0;

  always @(negedge clk) begin
    if (s_valid && s_ready) acc_n <= acc_n + 1;
    if (hdr_valid) hv_n <= hv_n + 1;
    if (pkt_done) pd_n <= pd_n + 1;
    if (err_trunc) et_n <= et_n + 1;
    if (err_trunc && pkt_done) etpd_n <= etpd_n + 1;
    if (m_valid && m_ready && got_n < 64) begin
      got_d[got_n] <= {m_seq, m_offset, m_len};
      got_n        <= got_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    acc0 = acc_n; hv0 = hv_n; pd0 = pd_n; et0 = et_n; etpd0 = etpd_n;
  endtask

  task automatic build_hdr(input logic [63:0] seq, input logic [15:0] cnt);
    for (int i = 0; i < 42; i++) pb[i] = 8'(i);
    for (int k = 0; k < 10; k++) pb[42+k] = 8'h30 + 8'(k);
    for (int k = 0; k < 8; k++) pb[52+k] = seq[63-8*k -: 8];
    pb[60] = cnt[15:8];
    pb[61] = cnt[7:0];
    plen = 62;
  endtask

  task automatic add_msg(input int len);
    pb[plen]   = 8'(len >> 8);
    pb[plen+1] = 8'(len);
    for (int j = 0; j < len; j++) pb[plen+2+j] = 8'hA0 + 8'(j);
    plen = plen + 2 + len;
  endtask

  // driver: sends at most max_beats beats of pb[0:plen-1]
  task automatic send_pkt(input int max_beats);
    int nb;
    int t;
    nb = (plen + BYTES - 1) / BYTES;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      for (int l = 0; l < BYTES; l++) begin
        s_data[8*l +: 8] = (b*BYTES + l < plen) ? pb[b*BYTES + l] : 8'h00;
        s_keep[l]        = (b*BYTES + l < plen);
      end
      s_last  = (b == nb - 1);
      s_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        t++;
        if (t > 300) begin
          chk("s_ready_timeout", {95'd0, s_ready}, 96'd1);
          s_valid = 1'b0;
          s_last  = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic chk_descs(input string tag);
    while (exp_q.size() > 0) begin
      chk({tag, "_avail"}, {95'd0, got_n > rd_i}, 96'd1);
      if (got_n > rd_i) begin
        chk(tag, got_d[rd_i], exp_q[0]);
        rd_i++;
      end
      void'(exp_q.pop_front());
    end
    chk({tag, "_extra"}, 96'(got_n - rd_i), 96'd0);
  endtask

  initial begin
    s_valid = 1'b0; s_last = 1'b0; s_keep = '0; s_data = '0; m_ready = 1'b0;
    idle(3);
    chk("rst_m_valid", {95'd0, m_valid}, 96'd0);
    chk("rst_hdr_valid", {95'd0, hdr_valid}, 96'd0);
    chk("rst_hdr_seq", {32'd0, hdr_seq}, 96'd0);
    chk("rst_pulses", {94'd0, pkt_done, err_trunc}, 96'd0);
    chk("rst_state", {94'd0, dbg_state}, 96'd0);
    chk("rst_m_seq", {32'd0, m_seq}, 96'd0);
    rst = 1'b1;
    m_ready = 1'b1;
    idle(2);

    // heartbeat
    snap(); build_hdr(64'h10, 16'h0000); send_pkt(99); idle(10);
    chk("t1_hv", 96'(hv_n - hv0), 96'd1);
    chk("t1_heartbeat", {94'd0, hdr_heartbeat, hdr_end}, 96'd2);
    chk("t1_seq", {32'd0, hdr_seq}, 96'h10);
    chk("t1_count", {80'd0, hdr_count}, 96'd0);
    chk("t1_session", {16'd0, hdr_session}, {16'd0, 80'h30313233343536373839});
    chk("t1_m_valid", {95'd0, m_valid}, 96'd0);
    chk("t1_done", 96'(pd_n - pd0), 96'd1);
    chk("t1_err", 96'(et_n - et0), 96'd0);
    chk_descs("t1_desc");

    // two messages, lengths 3 and 11
    snap(); build_hdr(64'h100, 16'd2); add_msg(3); add_msg(11); send_pkt(99); idle(10);
    exp_q.push_back({64'h100, 16'd64, 16'd3});
    exp_q.push_back({64'h101, 16'd69, 16'd11});
    chk_descs("t2_desc");
    chk("t2_hdr", {16'd0, hdr_seq, hdr_count}, {16'd0, 64'h100, 16'd2});
    chk("t2_heartbeat", {94'd0, hdr_heartbeat, hdr_end}, 96'd0);
    chk("t2_err", 96'(et_n - et0), 96'd0);
    chk("t2_done", 96'(pd_n - pd0), 96'd1);

    // second length field at bytes 71..72 straddles beats 8 and 9
    snap(); build_hdr(64'h200, 16'd2); add_msg(7); add_msg(261); send_pkt(99); idle(10);
    exp_q.push_back({64'h200, 16'd64, 16'd7});
    exp_q.push_back({64'h201, 16'd73, 16'd261});
    chk_descs("t3_desc");
    chk("t3_beats", 96'(acc_n - acc0), 96'd42);
    chk("t3_err", 96'(et_n - et0), 96'd0);
    chk("t3_done", 96'(pd_n - pd0), 96'd1);

    // eight zero-length messages against a stalled consumer
    m_ready = 1'b0;
    snap(); build_hdr(64'h300, 16'd8);
    for (int i = 0; i < 8; i++) add_msg(0);
    fork
      send_pkt(99);
      begin
        idle(20);
        chk("t4_m_valid", {95'd0, m_valid}, 96'd1);
        chk("t4_s_ready_low", {95'd0, s_ready}, 96'd0);
        chk("t4_head", {32'd0, m_seq}, 96'h300);
        chk("t4_beats_held", 96'(acc_n - acc0), 96'd9);
        chk("t4_no_pop", 96'(got_n - rd_i), 96'd0);
        m_ready = 1'b1;
      end
    join
    idle(20);
    for (int i = 0; i < 8; i++) exp_q.push_back({64'h300 + 64'(i), 16'(64 + 2*i), 16'd0});
    chk_descs("t4_desc");
    chk("t4_err", 96'(et_n - et0), 96'd0);
    chk("t4_done", 96'(pd_n - pd0), 96'd1);

    // count 3 but only two message blocks present
    snap(); build_hdr(64'h400, 16'd3); add_msg(3); add_msg(4); send_pkt(99); idle(10);
    exp_q.push_back({64'h400, 16'd64, 16'd3});
    exp_q.push_back({64'h401, 16'd69, 16'd4});
    chk_descs("t5_desc");
    chk("t5_err", 96'(et_n - et0), 96'd1);
    chk("t5_err_with_done", 96'(etpd_n - etpd0), 96'd1);
    chk("t5_done", 96'(pd_n - pd0), 96'd1);
    chk("t5_hv", 96'(hv_n - hv0), 96'd1);

    // end-of-session header
    snap(); build_hdr(64'h500, 16'hFFFF); send_pkt(99); idle(10);
    chk("t7_end", {94'd0, hdr_heartbeat, hdr_end}, 96'd1);
    chk("t7_err", 96'(et_n - et0), 96'd0);
    chk_descs("t7_desc");

    // header cut short at 50 bytes
    snap(); build_hdr(64'h777, 16'd1); plen = 50; send_pkt(99); idle(10);
    chk("t8_hv", 96'(hv_n - hv0), 96'd0);
    chk("t8_err", 96'(et_n - et0), 96'd1);
    chk("t8_done", 96'(pd_n - pd0), 96'd1);
    chk("t8_seq_held", {32'd0, hdr_seq}, 96'h500);

    // reset in the middle of the message walk
    m_ready = 1'b0;
    build_hdr(64'h550, 16'd3); add_msg(3); add_msg(11); send_pkt(9); idle(5);
    chk("t6_state_msgs", {94'd0, dbg_state}, 96'd2);
    chk("t6_m_valid_pre", {95'd0, m_valid}, 96'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_m_valid_rst", {95'd0, m_valid}, 96'd0);
    chk("t6_m_fields_rst", {m_seq, m_offset, m_len}, 96'd0);
    chk("t6_hdr_rst", {16'd0, hdr_seq, hdr_count}, 96'd0);
    chk("t6_state_rst", {94'd0, dbg_state}, 96'd0);
    idle(2);
    rst = 1'b1;
    m_ready = 1'b1;
    idle(2);
    snap(); build_hdr(64'h600, 16'd1); add_msg(2); send_pkt(99); idle(10);
    exp_q.push_back({64'h600, 16'd64, 16'd2});
    chk_descs("t6_desc");
    chk("t6_hdr", {16'd0, hdr_seq, hdr_count}, {16'd0, 64'h600, 16'd1});
    chk("t6_err", 96'(et_n - et0), 96'd0);
    chk("t6_done", 96'(pd_n - pd0), 96'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
